gc_response_rx: RTL

GC_RESPONSE_RX -- requirements
Module: gc_response_rx

---
 rtl/gc_response_rx.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/gc_response_rx.sv
// GameCube controller response receiver: decodes 24-bit ID or 64-bit button frames from the open-drain line.
// Optional stop-bit validation is enabled by defining GC_RX_STOP_CHECK_EN.
module gc_response_rx #(
   parameter int CLKS_PER_US = 100
) (
   input  logic        clk100mhz,
   input  logic        reset_n,
   input  logic        data_in,
   input  logic        send,
   input  logic        controller_init,
   output logic [23:0] wavebird_id,
   output logic        wavebird_id_ready,
   output logic [63:0] button_data,
   output logic        button_data_ready,
   output logic        rx_error
);

   typedef enum logic [2:0] {IDLE, ARMED, LOW, HIGH, STOP, DONE} state_t;

   localparam int ARM_CYC = 200 * CLKS_PER_US;
   localparam int TMR_W   = $clog2(ARM_CYC + 1);
   localparam int THR_I   = (2 * CLKS_PER_US > 1023) ? 1023 : 2 * CLKS_PER_US;
   localparam int LONG_I  = (5 * CLKS_PER_US > 1023) ? 1023 : 5 * CLKS_PER_US;
   localparam logic [TMR_W-1:0] ARM_LAST = TMR_W'(ARM_CYC - 1);
   localparam logic [9:0]       BIT_THR  = 10'(THR_I);
   localparam logic [9:0]       LONG_T   = 10'(LONG_I);

   state_t      state_r, state_nxt_s;
   logic        sync1_r, line_r, line_prev_r, send_prev_r;
   logic        mode24_r;
   logic [9:0]  cnt_r;
   logic [TMR_W-1:0] tmr_r;
   logic [6:0]  bit_cnt_r;
   logic [63:0] shift_r;
   logic [23:0] wavebird_id_r;
   logic [63:0] button_data_r;
   logic        wavebird_id_ready_r, button_data_ready_r, rx_error_r;

   logic        line_fall_s, line_rise_s, send_fall_s, send_rise_s;
   logic        last_bit_s, bit_s;
   logic        cnt_clr_s, cnt_inc_s, tmr_inc_s, arm_s, shift_s, err_s, done_s;
   logic [6:0]  frame_len_s;
`ifdef GC_RX_STOP_CHECK_EN
   logic        stop_low_r, stop_low_set_s;
`endif

   assign line_fall_s = line_prev_r & ~line_r;
   assign line_rise_s = ~line_prev_r & line_r;
   assign send_fall_s = send_prev_r & ~send;
   assign send_rise_s = ~send_prev_r & send;
   assign frame_len_s = mode24_r ? 7'd24 : 7'd64;
   assign last_bit_s  = (bit_cnt_r + 7'd1) == frame_len_s;
   assign bit_s       = cnt_r < BIT_THR;

   // Next-state and datapath strobes for the frame decoder
   always_comb begin
      state_nxt_s = state_r;
      cnt_clr_s   = 1'b0;
      cnt_inc_s   = 1'b0;
      tmr_inc_s   = 1'b0;
      arm_s       = 1'b0;
      shift_s     = 1'b0;
      err_s       = 1'b0;
      done_s      = 1'b0;
`ifdef GC_RX_STOP_CHECK_EN
      stop_low_set_s = 1'b0;
`endif
      if (send_rise_s && (state_r != IDLE)) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (send_fall_s) begin
                  arm_s       = 1'b1;
                  state_nxt_s = ARMED;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            ARMED: begin
               if (line_fall_s) begin
                  cnt_clr_s   = 1'b1;
                  state_nxt_s = LOW;
               end else if (tmr_r >= ARM_LAST) begin
                  state_nxt_s = IDLE;
               end else begin
                  tmr_inc_s = 1'b1;
               end
            end
            LOW: begin
               if (line_rise_s) begin
                  shift_s     = 1'b1;
                  cnt_clr_s   = 1'b1;
                  state_nxt_s = last_bit_s ? STOP : HIGH;
               end else if (cnt_r >= LONG_T) begin
                  err_s       = 1'b1;
                  state_nxt_s = IDLE;
               end else begin
                  cnt_inc_s = 1'b1;
               end
            end
            HIGH: begin
               if (line_fall_s) begin
                  cnt_clr_s   = 1'b1;
                  state_nxt_s = LOW;
               end else if (cnt_r >= LONG_T) begin
                  err_s       = 1'b1;
                  state_nxt_s = IDLE;
               end else begin
                  cnt_inc_s = 1'b1;
               end
            end
            STOP: begin
`ifdef GC_RX_STOP_CHECK_EN
               // First wait for the stop pulse to start, then require it to be short
               if (!stop_low_r) begin
                  if (line_fall_s) begin
                     cnt_clr_s      = 1'b1;
                     stop_low_set_s = 1'b1;
                  end else if (cnt_r >= LONG_T) begin
                     err_s       = 1'b1;
                     state_nxt_s = IDLE;
                  end else begin
                     cnt_inc_s = 1'b1;
                  end
               end else begin
                  if (line_rise_s) begin
                     state_nxt_s = DONE;
                  end else if (cnt_r >= BIT_THR) begin
                     err_s       = 1'b1;
                     state_nxt_s = IDLE;
                  end else begin
                     cnt_inc_s = 1'b1;
                  end
               end
`else
               state_nxt_s = DONE;
`endif
            end
            DONE: begin
               done_s      = 1'b1;
               state_nxt_s = IDLE;
            end
            default: begin
               state_nxt_s = IDLE;
            end
         endcase
      end
   end

   // Synchronizer, edge history and state register
   always_ff @(posedge clk100mhz or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r     <= 1'b1;
         line_r      <= 1'b1;
         line_prev_r <= 1'b1;
         send_prev_r <= 1'b0;
         state_r     <= IDLE;
      end else begin
         sync1_r     <= data_in;
         line_r      <= sync1_r;
         line_prev_r <= line_r;
         send_prev_r <= send;
         state_r     <= state_nxt_s;
      end
   end

   // Counters, shift register and registered outputs
   always_ff @(posedge clk100mhz or negedge reset_n) begin
      if (!reset_n) begin
         mode24_r            <= 1'b0;
         cnt_r               <= 10'd0;
         tmr_r               <= '0;
         bit_cnt_r           <= 7'd0;
         shift_r             <= 64'd0;
         wavebird_id_r       <= 24'd0;
         button_data_r       <= 64'd0;
         wavebird_id_ready_r <= 1'b0;
         button_data_ready_r <= 1'b0;
         rx_error_r          <= 1'b0;
      end else begin
         if (cnt_clr_s) begin
            cnt_r <= 10'd0;
         end else if (cnt_inc_s && (cnt_r != 10'h3FF)) begin
            cnt_r <= cnt_r + 10'd1;
         end else begin
            cnt_r <= cnt_r;
         end
         if (arm_s) begin
            mode24_r  <= controller_init;
            tmr_r     <= '0;
            bit_cnt_r <= 7'd0;
         end else if (tmr_inc_s) begin
            tmr_r <= tmr_r + TMR_W'(1);
         end else if (shift_s) begin
            bit_cnt_r <= bit_cnt_r + 7'd1;
         end else begin
            tmr_r <= tmr_r;
         end
         if (shift_s) begin
            shift_r <= {shift_r[62:0], bit_s};
         end else begin
            shift_r <= shift_r;
         end
         if (done_s && mode24_r) begin
            wavebird_id_r <= shift_r[23:0];
         end else begin
            wavebird_id_r <= wavebird_id_r;
         end
         if (done_s && !mode24_r) begin
            button_data_r <= shift_r;
         end else begin
            button_data_r <= button_data_r;
         end
         wavebird_id_ready_r <= done_s & mode24_r;
         button_data_ready_r <= done_s & ~mode24_r;
         rx_error_r          <= err_s;
      end
   end

`ifdef GC_RX_STOP_CHECK_EN
   // Stop-pulse phase flag, cleared whenever STOP is left
   always_ff @(posedge clk100mhz or negedge reset_n) begin
      if (!reset_n) begin
         stop_low_r <= 1'b0;
      end else begin
         stop_low_r <= (state_nxt_s == STOP) && (stop_low_r || stop_low_set_s);
      end
   end
`endif

   assign wavebird_id       = wavebird_id_r;
   assign wavebird_id_ready = wavebird_id_ready_r;
   assign button_data       = button_data_r;
   assign button_data_ready = button_data_ready_r;
   assign rx_error          = rx_error_r;

endmodule
